// File: rtl/delay_line_var.sv
// Runtime-variable delay line: circular buffer of {valid, data} read k entries behind the write pointer.
// Optional output register enabled by defining DELAY_LINE_VAR_REGOUT_EN.
module delay_line_var #(
   parameter int WIDTH      = 8,
   parameter int MAX_CYCLES = 16,
   localparam int DW        = $clog2(MAX_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [DW-1:0]    delay,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] d,
   output logic             out_valid,
   output logic [WIDTH-1:0] q
);

   localparam int AW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [AW-1:0] LAST  = AW'(MAX_CYCLES - 1);
   localparam logic [DW-1:0] KMAX  = DW'(MAX_CYCLES);
   localparam logic [DW:0]   DEPTH = (DW + 1)'(MAX_CYCLES);

   logic [WIDTH-1:0]      mem_data [MAX_CYCLES];
   logic [MAX_CYCLES-1:0] mem_valid;
   logic [AW-1:0]         wr_ptr;
   logic [DW-1:0]         k;
   logic [DW:0]           ptr_ext;
   logic [DW:0]           k_ext;
   logic [DW:0]           rd_sum;
   logic [AW-1:0]         rd_idx;
   logic                  rd_valid;
   logic [WIDTH-1:0]      rd_data;
   logic                  raw_valid;
   logic [WIDTH-1:0]      raw_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         mem_valid <= '0;
         for (int i = 0; i < MAX_CYCLES; i++) begin
            mem_data[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr    <= '0;
         mem_valid <= '0;
      end else if (en) begin
         mem_valid[wr_ptr] <= in_valid;
         mem_data[wr_ptr]  <= d;
         wr_ptr            <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
   end

   // Read address wraps explicitly so any depth works, not just powers of two.
   always_comb begin
      k       = (delay > KMAX) ? KMAX : delay;
      ptr_ext = (DW + 1)'(wr_ptr);
      k_ext   = (DW + 1)'(k);
      rd_sum  = (ptr_ext >= k_ext) ? (ptr_ext - k_ext) : (ptr_ext + DEPTH - k_ext);
      rd_idx  = AW'(rd_sum);
      rd_valid = mem_valid[rd_idx];
      rd_data  = mem_data[rd_idx];
   end

   always_comb begin
      raw_valid = 1'b0;
      raw_q     = '0;
      if (k == '0) begin
         raw_valid = in_valid;
         raw_q     = in_valid ? d : '0;
      end else begin
         raw_valid = rd_valid;
         raw_q     = rd_valid ? rd_data : '0;
      end
   end

`ifdef DELAY_LINE_VAR_REGOUT_EN
   logic             reg_valid;
   logic [WIDTH-1:0] reg_q;

   // Flush drops only the valid bit; q is masked by it anyway.
   always_ff @(posedge clk) begin
      if (!rst) begin
         reg_valid <= 1'b0;
         reg_q     <= '0;
      end else begin
         if (en) begin
            reg_valid <= raw_valid;
            reg_q     <= raw_q;
         end
         if (flush) begin
            reg_valid <= 1'b0;
         end
      end
   end

   assign out_valid = reg_valid;
   assign q         = reg_valid ? reg_q : '0;
`else
   assign out_valid = raw_valid;
   assign q         = raw_q;
`endif

endmodule

// File: tb/tb_delay_line_var.sv
// Testbench for delay_line_var: history-queue reference model checked every cycle,
// plus directed literal expectations for fill, passthrough, stall, clamp, delay change, flush and reset.
module tb_delay_line_var;

   localparam int WIDTH = 8;
   localparam int MAXC  = 5;
   localparam int DW    = $clog2(MAXC + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             flush;
   logic [DW-1:0]    delay;
   logic             in_valid;
   logic [WIDTH-1:0] d;
   logic             out_valid;
   logic [WIDTH-1:0] q;

   int checks = 0;
   int passes = 0;
   bit check_on = 1'b0;

   // Newest written sample at the front; entry k-1 is the sample written k enabled cycles ago.
   logic [WIDTH:0] hist[$];

   always #5 clk = ~clk;

   delay_line_var #(.WIDTH(WIDTH), .MAX_CYCLES(MAXC)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .flush(flush),
      .delay(delay),
      .in_valid(in_valid),
      .d(d),
      .out_valid(out_valid),
      .q(q)
   );

   task automatic clear_model();
      hist.delete();
      for (int i = 0; i < MAXC; i++) hist.push_back('0);
   endtask

   always @(posedge clk) begin
      if (!rst || flush) begin
         clear_model();
      end else if (en) begin
         hist.push_front({in_valid, d});
         void'(hist.pop_back());
      end
   end

   always @(negedge clk) begin
      int               k;
      logic             ev;
      logic [WIDTH-1:0] eq;
      if (check_on) begin
         k = (int'(delay) > MAXC) ? MAXC : int'(delay);
         if (k == 0) begin
            ev = in_valid;
            eq = in_valid ? d : '0;
         end else begin
            ev = hist[k-1][WIDTH];
            eq = ev ? hist[k-1][WIDTH-1:0] : '0;
         end
         checks++;
         if (out_valid === ev && q === eq) passes++;
         else $display("[TB] FAIL model t=%0t k=%0d got v=%b q=%h want v=%b q=%h",
                       $time, k, out_valid, q, ev, eq);
      end
   end

   task automatic applyStimulus(input logic r, input logic e, input logic f, input int dl,
                                input logic v, input logic [WIDTH-1:0] data);
      @(posedge clk);
      #1;
      rst      = r;
      en       = e;
      flush    = f;
      delay    = DW'(dl);
      in_valid = v;
      d        = data;
   endtask

   task automatic checkOutput(input string name, input logic ev, input logic [WIDTH-1:0] eq);
      @(negedge clk);
      checks++;
      if (out_valid === ev && q === eq) passes++;
      else $display("[TB] FAIL %s t=%0t got v=%b q=%h want v=%b q=%h",
                    name, $time, out_valid, q, ev, eq);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; flush = 1'b0; delay = '0; in_valid = 1'b0; d = '0;
      clear_model();
      @(posedge clk);
      #1 check_on = 1'b1;

      // Fill after reset at delay 3
      applyStimulus(1'b0, 1'b1, 1'b0, 3, 1'b0, 8'h00);
      checkOutput("reset_state", 1'b0, 8'h00);
      for (int i = 1; i <= 13; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 3, 1'b1, WIDTH'(i));
         checkOutput("fill", i > 3, (i > 3) ? WIDTH'(i - 3) : 8'h00);
      end

      applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b1, 8'hA5);
      checkOutput("pass_valid", 1'b1, 8'hA5);
      applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h5A);
      checkOutput("pass_invalid", 1'b0, 8'h00);

      // Stall: en low for two cycles after sample 4
      applyStimulus(1'b1, 1'b1, 1'b1, 2, 1'b0, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b1, WIDTH'(i));
         checkOutput("stall_stream", i > 2, (i > 2) ? WIDTH'(i - 2) : 8'h00);
         if (i == 4) begin
            for (int s = 0; s < 2; s++) begin
               applyStimulus(1'b1, 1'b0, 1'b0, 2, 1'b1, 8'hEE);
               checkOutput("stall_hold", 1'b1, 8'h03);
            end
         end
      end

      // Wrap at full depth, then an over-range delay clamps to the same result
      applyStimulus(1'b1, 1'b1, 1'b1, 5, 1'b0, 8'h00);
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, (i <= 12) ? 5 : 7, 1'b1, WIDTH'(i));
         checkOutput("wrap_clamp", i > 5, (i > 5) ? WIDTH'(i - 5) : 8'h00);
      end
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, (i < 10) ? 5 : 7, 1'($urandom_range(0, 1)),
                       WIDTH'($urandom));
      end

      // Delay 4 -> 2 after sample 10, then flush at delay 2
      applyStimulus(1'b1, 1'b1, 1'b1, 4, 1'b0, 8'h00);
      for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4, 1'b1, WIDTH'(i));
      checkOutput("before_change", 1'b1, 8'h06);
      applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b1, 8'd11);
      checkOutput("after_change", 1'b1, 8'h09);
      applyStimulus(1'b1, 1'b1, 1'b1, 2, 1'b1, 8'd12);
      checkOutput("flush_cycle", 1'b1, 8'd10);
      applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b1, 8'd13);
      checkOutput("flush_empty1", 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b1, 8'd14);
      checkOutput("flush_empty2", 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b1, 8'd15);
      checkOutput("flush_refill", 1'b1, 8'd13);

      // Reset for one cycle mid-stream at delay 3
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3, 1'b1, WIDTH'(i));
      applyStimulus(1'b0, 1'b1, 1'b0, 3, 1'b1, 8'd7);
      checkOutput("reset_cycle", 1'b1, 8'd4);
      for (int i = 8; i <= 10; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 3, 1'b1, WIDTH'(i));
         checkOutput("post_reset_empty", 1'b0, 8'h00);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 3, 1'b1, 8'd11);
      checkOutput("post_reset_refill", 1'b1, 8'd8);

      // Random traffic: occasional reset/flush, stalls and delay changes
      begin
         int dl;
         dl = 3;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) dl = $urandom_range(0, 7);
            applyStimulus(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) < 8),
                          1'($urandom_range(0, 49) == 0), dl, 1'($urandom_range(0, 3) != 0),
                          WIDTH'($urandom));
         end
      end

      @(posedge clk);
      #1 check_on = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/delay_line_var.md
# delay_line_var

Runtime-variable delay line: successor to the fixed-depth register-chain delay, built as a circular buffer with per-entry valid tracking. The delay is selectable per cycle from 0 to MAX_CYCLES enabled cycles. It also provides stall (en), synchronous flush, and an optional output register. It sits in datapaths that must align streams whose relative latency is only known at run time, for example after a configurable filter.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- MAX_CYCLES, 16: maximum delay and buffer depth, ≥1; any value, not required to be a power of two.
- DW, $clog2(MAX_CYCLES+1): width of the delay port (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  advance enable; when low, all state holds.
- flush  in  1  synchronous clear of all stored valid bits.
- delay  in  DW  requested delay in enabled cycles; values above MAX_CYCLES are clamped to MAX_CYCLES.
- in_valid  in  1  qualifies d.
- d  in  WIDTH  input sample.
- out_valid  out  1  qualifies q.
- q  out  WIDTH  delayed sample; forced to 0 whenever out_valid=0.

## Operation
- Storage: MAX_CYCLES entries of {valid, data}, plus write pointer wr_ptr in 0..MAX_CYCLES-1.
- Write, when en=1 and flush=0: entry[wr_ptr] ← {in_valid, d}; wr_ptr ← wr_ptr+1, wrapping MAX_CYCLES-1 → 0. Invalid samples are written too, with valid=0.
- Read, with k = min(delay, MAX_CYCLES):
  - k=0: out_valid=in_valid, q=d (combinational passthrough).
  - k≥1: reads entry at (wr_ptr−k) mod MAX_CYCLES, which is the sample written k enabled cycles ago. The subtraction wraps explicitly and is valid for non-power-of-two depths.
- en=0: no write and no pointer move. For k≥1 the output holds, unless delay itself changes.
- Delay change: takes effect in the same cycle, because the read address is combinational from delay.
  - Decrease by n: the next n samples are skipped.
  - Increase by n: the last n samples are re-presented with their stored valid bits.
  - No protection is provided; users assert flush if this is unacceptable.
- Flush: valid bits of all entries ← 0 and wr_ptr ← 0; the current input is discarded. It acts regardless of en. For k=0 the passthrough is unaffected.
- Reset (rst=0): all valid and data bits ← 0, wr_ptr ← 0. Reset has priority over flush and en.

## Timing
- Reset values: out_valid=0 and q=0 for k≥1. For k=0, out_valid and q follow in_valid and d even while in reset.
- Latency:
  - Without the register option: exactly k enabled cycles, with 0 combinational paths from d to q for k≥1.
  - With the register option: see Configuration.
- Fill: after reset or flush, out_valid stays 0 for the first k enabled cycles, because the entries read are still invalid.
- Flush in cycle t: out_valid reflects the pre-flush state in cycle t, and is 0 from t+1 until k new writes have occurred.
- Simultaneous en=1 and flush=1: flush wins; no write occurs.
- Wrap: continuous operation at k=MAX_CYCLES reads the entry about to be overwritten; the read returns the old value in the same cycle.

## Configuration
- DELAY_LINE_VAR_REGOUT_EN defined: adds an output register {out_valid, q}.
  - The register loads when en=1 and holds otherwise.
  - It is cleared by rst; flush clears only its valid bit.
  - Total latency becomes k+1 enabled cycles, including k=0.
- Undefined: the outputs are combinational from the buffer read, as described above.

## Test plan
- Delay/fill: reset, delay=3, in_valid=1, d=1..10 → out_valid=0 for 3 cycles, then q=1,2,…,10 on consecutive cycles.
- Passthrough: delay=0, d=0xA5, in_valid=1 → q=0xA5 and out_valid=1 in the same cycle; with in_valid=0 → q=0.
- Stall: delay=2, stream 1..8 with en=0 for 2 cycles after sample 4 → q holds during the stall, and the sequence resumes with no loss or duplication.
- Wrap and clamp: MAX_CYCLES=5, delay=5, 20 samples → each q equals d from 5 cycles earlier. Then delay=7 → identical behaviour to delay=5.
- Delay change and flush: delay 4→2 mid-stream after sample 10 → next q=9, skipping 7 and 8. Flush with delay=2 → out_valid=0 for 2 cycles, then the new samples appear.
- Reset mid-stream: rst=0 for 1 cycle at delay=3 → out_valid=0 and q=0 for 3 cycles afterwards; with DELAY_LINE_VAR_REGOUT_EN defined, latency is 4.
